temporal_spike_encoder: RTL
===========================

# temporal_spike_encoder

Transmitter end of the temporal-coding spike interface that neurons consume. Converts per-input binary spike-time values into single pulses of width 2^WRES unit clocks, positioned within each gamma wave. The pulses drive a neuron's `resp_func`/input-spike bus. Data is accepted through a valid/ready port into a one-entry staging buffer and launched on each `grst` gamma pulse.

## Interface
- `INP`, 4, number of spike lanes (one per neuron synapse)
- `TRES`, 3, bits per spike-time value; NULL code = 2^TRES-1 (no spike)
- `WRES`, 3, weight resolution; pulse width W = 2^WRES cycles
- Derived: CMAX = (2^TRES-1) + W (counter saturation value)

Ports:
- `clk` input 1 unit clock for temporal encoding
- `rstb` input 1 reset; one clock; reset is asynchronous and active-low
- `grst` input 1 one-cycle gamma pulse; starts a new wave
- `in_valid` input 1 spike-time word offered
- `in_ready` output 1 staging buffer empty, word accepted on `in_valid & in_ready`
- `in_data` input INP*TRES lane i value at bits [i*TRES +: TRES]
- `input_spikes` output INP registered spike pulses to neuron
- `busy` output 1 wave in progress (counter not saturated, wave valid)
- `underrun` output 1 one-cycle pulse: `grst` arrived with staging empty

## Operation
- State: staging reg + `staged_full`; active reg + `active_valid`; wave counter `cnt` (width to hold CMAX).
- Handshake: `in_ready = !staged_full`. On accept edge: staging <= `in_data`, `staged_full` <= 1.
- On `grst` edge:
  - `cnt` <= 0.
  - staged_full=1: active <= staging, `active_valid` <= 1, `staged_full` <= 0.
  - staged_full=0: `active_valid` <= 0, `underrun` pulses 1 cycle.
- `cnt` increments each cycle while < CMAX; saturates at CMAX.
- Lane i (value v): `input_spikes[i]` = 1 iff `active_valid`, v != NULL, and v <= cnt < v+W, evaluated on the same cycle's `cnt`. Outputs are flops: next-state logic uses next `cnt`/active.
- `busy` = `active_valid & (cnt < CMAX)`.
- Mid-wave `grst`: wave restarts immediately; in-flight pulses truncated; next cycle reflects the new wave (or all-zero when underrun).
- `grst` with simultaneous accept on empty staging: the launched wave is empty (underrun); the accepted word stays staged for the following `grst`. No bypass.
- Accept blocked while `staged_full`; `in_valid` may be held without loss.

## Timing
- Reset values: `input_spikes`=0, `busy`=0, `underrun`=0, `in_ready`=1; `cnt`=CMAX, `active_valid`=0, `staged_full`=0. Asynchronous on `rstb` fall, including mid-wave.
- `grst` sampled at edge E: during cycle E+1, `cnt`=0 and lane with v=0 is high. Lane v high cycles E+1+v .. E+v+W.
- `in_ready` falls the cycle after accept; rises the cycle after `grst` consumes staging.
- `underrun` high exactly cycle E+1.
- `busy` falls the cycle `cnt` reaches CMAX (E+1+CMAX).

## Test plan
- Values {v3=7,v2=5,v1=0,v0=2} loaded, `grst` at E: [1] high E+1..E+8; [0] E+3..E+10; [2] E+6..E+13; [3] never; `busy` low from E+16.
- Back-pressure: accept word A, hold `in_valid` with word B: `in_ready`=0 until `grst`. B accepted at E+1. Wave uses A. Next `grst` launches B.
- `grst` with empty staging: `underrun`=1 at E+1 only; `input_spikes`=0 for the whole wave; `busy`=0.
- Mid-wave `grst` at cnt=4 with staged all-zero values: all lanes high at E'+1..E'+8. The prior wave's later pulses never appear.
- `rstb` low at cnt=6 during active wave: all outputs 0 asynchronously, `in_ready`=1. After release, no spikes until a word and `grst`.
- `grst` coincident with accept on empty staging: `underrun` pulses, no spikes. The next `grst` launches that word with correct timing.

Source files
------------

// File: rtl/temporal_spike_encoder.sv
// ----------------------------------------------------------------------------
// temporal_spike_encoder
//
// Transmitter end of a temporal-coding spike interface. Each lane carries a
// TRES-bit spike time. On every gamma pulse (grst) the staged word becomes the
// active wave. Each lane then emits one pulse that is W = 2^WRES clocks wide
// and starts v clocks into the wave. The all-ones code means "no spike".
//
// Ports:
//   clk          unit clock for temporal encoding
//   rstb         asynchronous active-low reset
//   grst         one-cycle gamma pulse; starts a new wave
//   in_valid     spike-time word offered
//   in_ready     staging buffer empty; word accepted on in_valid & in_ready
//   in_data      lane i spike time at bits [i*TRES +: TRES]
//   input_spikes registered per-lane spike pulses towards the neuron
//   busy         wave in progress (active word valid, counter not saturated)
//   underrun     one-cycle pulse: grst arrived while staging was empty
// ----------------------------------------------------------------------------
module temporal_spike_encoder #(
    parameter int INP  = 4,
    parameter int TRES = 3,
    parameter int WRES = 3
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  grst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INP*TRES-1:0]   in_data,
    output logic [INP-1:0]        input_spikes,
    output logic                  busy,
    output logic                  underrun
);

    localparam int NULL_CODE = (2 ** TRES) - 1;
    localparam int W         = 2 ** WRES;
    localparam int CMAX      = NULL_CODE + W;
    localparam int CW        = $clog2(CMAX + 1);
    // One extra bit so that v + W can be formed without wrapping.
    localparam int SW        = CW + 1;

    logic [INP*TRES-1:0] staging;
    logic                staged_full;
    logic [INP*TRES-1:0] active;
    logic                active_valid;
    logic [CW-1:0]       cnt;

    logic [CW-1:0]       cnt_next;
    logic [INP*TRES-1:0] active_next;
    logic                active_valid_next;
    logic [INP-1:0]      spikes_next;
    logic [TRES-1:0]     lane_v;
    logic                accept;

    assign in_ready = !staged_full;
    assign accept   = in_valid & in_ready;
    assign busy     = active_valid && (cnt < CW'(CMAX));

    // Next wave state. The spike flops are computed from these values, so a
    // registered output lines up with the counter value of the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        cnt_next          = cnt;
        active_next       = active;
        active_valid_next = active_valid;
        if (grst) begin
            cnt_next = '0;
            if (staged_full) begin
                active_next       = staging;
                active_valid_next = 1'b1;
            end else begin
                active_valid_next = 1'b0;
            end
        end else if (cnt < CW'(CMAX)) begin
            cnt_next = cnt + CW'(1);
        end
    end

    // Lane i is high while v <= cnt < v + W, unless the lane carries NULL.
    always_comb begin
        spikes_next = '0;
        lane_v      = '0;
        for (int i = 0; i < INP; i++) begin
            lane_v = active_next[i*TRES +: TRES];
            if (active_valid_next &&
                (lane_v != TRES'(NULL_CODE)) &&
                ({1'b0, cnt_next} >= SW'(lane_v)) &&
                ({1'b0, cnt_next} <  SW'(lane_v) + SW'(W))) begin
                spikes_next[i] = 1'b1;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            staging      <= '0;
            staged_full  <= 1'b0;
            active       <= '0;
            active_valid <= 1'b0;
            cnt          <= CW'(CMAX);
            input_spikes <= '0;
            underrun     <= 1'b0;
        end else begin
            // An accept implies staging was empty, so a coincident grst
            // launches an empty wave and the new word waits for the next grst.
            if (accept) begin
                staging     <= in_data;
                staged_full <= 1'b1;
            end else if (grst) begin
                staged_full <= 1'b0;
            end
            active       <= active_next;
            active_valid <= active_valid_next;
            cnt          <= cnt_next;
            input_spikes <= spikes_next;
            underrun     <= grst & !staged_full;
        end
    end

endmodule
